// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction-fetch stage of the five-stage RV64I core.
//
// Owns the PC and keeps at most one fetch in flight on a req/ack instruction
// memory port. A returned word is registered with its PC for id_stage. When
// decode stalls, one extra word is parked in a skid slot. Branch/jump
// redirects from execute discard every wrong-path fetch. A request that is
// already in flight is never aborted or re-addressed: its data is dropped.
//
// Ports:
//   clk             core clock, rising edge
//   rst             asynchronous active-high reset
//   stall           decode cannot accept; output held while inst_valid & stall
//   redirect_valid  taken branch/jump resolved this cycle
//   redirect_pc     redirect target (bits [1:0] ignored)
//   imem_req        fetch request, held until imem_ack
//   imem_addr       fetch address, stable while the request is pending
//   imem_ack        read complete (may be combinational with imem_req)
//   imem_rdata      instruction word, valid with imem_ack
//   inst_valid      inst/inst_addr hold a valid instruction
//   inst            instruction to id_stage
//   inst_addr       PC of inst
// -----------------------------------------------------------------------------
module if_stage #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_addr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2,
    S_FULL = 2'd3
  } state_t;

  state_t      state_r,      state_n;
  logic [63:0] pc_r,         pc_n;
  logic [63:0] pc_old_r,     pc_old_n;
  logic [31:0] skid_inst_r,  skid_inst_n;
  logic [63:0] skid_addr_r,  skid_addr_n;
  logic        inst_valid_r, inst_valid_n;
  logic [31:0] inst_r,       inst_n;
  logic [63:0] inst_addr_r,  inst_addr_n;

  logic        can_accept_s;
  logic [63:0] pc_inc_s;

  assign can_accept_s = ~inst_valid_r | ~stall;
  // Modular 64-bit increment: ...FFFC + 4 wraps to 0.
  assign pc_inc_s     = pc_r + 64'd4;

  // Memory port is decoded from registered state only, so there is no
  // combinational path from imem_ack, stall or redirect_valid.
  assign imem_req   = (state_r == S_REQ) || (state_r == S_DROP);
  assign imem_addr  = (state_r == S_DROP) ? pc_old_r : pc_r;
  assign inst_valid = inst_valid_r;
  assign inst       = inst_r;
  assign inst_addr  = inst_addr_r;

  // Next-state and datapath update for the fetch FSM.
  always_comb begin
    state_n     = state_r;
    pc_n        = pc_r;
    pc_old_n    = pc_old_r;
    skid_inst_n = skid_inst_r;
    skid_addr_n = skid_addr_r;
    inst_n      = inst_r;
    inst_addr_n = inst_addr_r;
    // A consumed (or empty) output goes invalid unless refilled below.
    if (can_accept_s) begin
      inst_valid_n = 1'b0;
    end else begin
      inst_valid_n = inst_valid_r;
    end

    if (redirect_valid) begin
      // Redirect wins over everything, including stall.
      pc_n         = {redirect_pc[63:2], 2'b00};
      inst_valid_n = 1'b0;
      skid_inst_n  = 32'd0;
      skid_addr_n  = 64'd0;
      case (state_r)
        S_IDLE: state_n = S_REQ;
        S_REQ: begin
          if (imem_ack) begin
            state_n = S_REQ;
          end else begin
            // Request still in flight: remember its address and drain it.
            state_n  = S_DROP;
            pc_old_n = pc_r;
          end
        end
        S_DROP: begin
          if (imem_ack) begin
            state_n = S_REQ;
          end else begin
            state_n = S_DROP;
          end
        end
        S_FULL:  state_n = S_REQ;
        default: state_n = S_IDLE;
      endcase
    end else begin
      case (state_r)
        S_IDLE: state_n = S_REQ;
        S_REQ: begin
          if (imem_ack) begin
            pc_n = pc_inc_s;
            if (can_accept_s) begin
              inst_valid_n = 1'b1;
              inst_n       = imem_rdata;
              inst_addr_n  = pc_r;
              state_n      = S_REQ;
            end else begin
              skid_inst_n = imem_rdata;
              skid_addr_n = pc_r;
              state_n     = S_FULL;
            end
          end else begin
            state_n = S_REQ;
          end
        end
        S_DROP: begin
          if (imem_ack) begin
            state_n = S_REQ;
          end else begin
            state_n = S_DROP;
          end
        end
        S_FULL: begin
          if (!stall) begin
            inst_valid_n = 1'b1;
            inst_n       = skid_inst_r;
            inst_addr_n  = skid_addr_r;
            state_n      = S_REQ;
          end else begin
            state_n = S_FULL;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_IDLE;
      pc_r         <= RESET_PC;
      pc_old_r     <= 64'd0;
      skid_inst_r  <= 32'd0;
      skid_addr_r  <= 64'd0;
      inst_valid_r <= 1'b0;
      inst_r       <= 32'd0;
      inst_addr_r  <= 64'd0;
    end else begin
      state_r      <= state_n;
      pc_r         <= pc_n;
      pc_old_r     <= pc_old_n;
      skid_inst_r  <= skid_inst_n;
      skid_addr_r  <= skid_addr_n;
      inst_valid_r <= inst_valid_n;
      inst_r       <= inst_n;
      inst_addr_r  <= inst_addr_n;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage -- directed, table-driven bench for if_stage.
// Memory model: rdata = imem_addr[31:0], ack granted only while requesting.
// -----------------------------------------------------------------------------
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_addr;
  logic        ack_en;

  int checks;
  int errors;

  if_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_addr      (inst_addr)
  );

  assign imem_ack   = ack_en & imem_req;
  assign imem_rdata = imem_addr[31:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        rv;
    logic [63:0] rpc;
    logic        ack;
    logic        exp_req;
    logic [63:0] exp_addr;
    logic        exp_valid;
    logic [63:0] exp_iaddr;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic setv(input int i, input logic s, input logic rv, input logic [63:0] rpc,
                      input logic ack, input logic er, input logic [63:0] ea,
                      input logic ev, input logic [63:0] eia);
    vecs[i].stall     = s;
    vecs[i].rv        = rv;
    vecs[i].rpc       = rpc;
    vecs[i].ack       = ack;
    vecs[i].exp_req   = er;
    vecs[i].exp_addr  = ea;
    vecs[i].exp_valid = ev;
    vecs[i].exp_iaddr = eia;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " req"},        {63'd0, imem_req},   64'd0);
    chk({tag, " addr"},       imem_addr,           64'h0000_0000_8000_0000);
    chk({tag, " valid"},      {63'd0, inst_valid}, 64'd0);
    chk({tag, " inst"},       {32'd0, inst},       64'd0);
    chk({tag, " inst_addr"},  inst_addr,           64'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 64'd0;
    ack_en = 1'b0;

    //     stall rv  rpc                     ack req addr                     valid inst_addr
    setv( 0, 1'b0, 1'b0, 64'd0,                  1'b1, 1'b0, 64'd0,                  1'b0, 64'd0);
    setv( 1, 1'b0, 1'b0, 64'd0,                  1'b1, 1'b1, 64'h0000_0000_8000_0000, 1'b0, 64'd0);
    setv( 2, 1'b0, 1'b0, 64'd0,                  1'b1, 1'b1, 64'h0000_0000_8000_0004, 1'b1, 64'h0000_0000_8000_0000);
    setv( 3, 1'b1, 1'b0, 64'd0,                  1'b1, 1'b1, 64'h0000_0000_8000_0008, 1'b1, 64'h0000_0000_8000_0004);
    setv( 4, 1'b1, 1'b0, 64'd0,                  1'b1, 1'b0, 64'd0,                  1'b1, 64'h0000_0000_8000_0004);
    setv( 5, 1'b1, 1'b0, 64'd0,                  1'b1, 1'b0, 64'd0,                  1'b1, 64'h0000_0000_8000_0004);
    setv( 6, 1'b0, 1'b0, 64'd0,                  1'b1, 1'b0, 64'd0,                  1'b1, 64'h0000_0000_8000_0004);
    setv( 7, 1'b0, 1'b0, 64'd0,                  1'b1, 1'b1, 64'h0000_0000_8000_000C, 1'b1, 64'h0000_0000_8000_0008);
    setv( 8, 1'b0, 1'b1, 64'h0000_0000_8000_1002, 1'b1, 1'b1, 64'h0000_0000_8000_0010, 1'b1, 64'h0000_0000_8000_000C);
    setv( 9, 1'b0, 1'b0, 64'd0,                  1'b1, 1'b1, 64'h0000_0000_8000_1000, 1'b0, 64'd0);
    setv(10, 1'b1, 1'b0, 64'd0,                  1'b1, 1'b1, 64'h0000_0000_8000_1004, 1'b1, 64'h0000_0000_8000_1000);
    setv(11, 1'b1, 1'b1, 64'h0000_0000_8000_2000, 1'b1, 1'b0, 64'd0,                  1'b1, 64'h0000_0000_8000_1000);
    setv(12, 1'b0, 1'b0, 64'd0,                  1'b0, 1'b1, 64'h0000_0000_8000_2000, 1'b0, 64'd0);
    setv(13, 1'b0, 1'b1, 64'h0000_0000_8000_3000, 1'b0, 1'b1, 64'h0000_0000_8000_2000, 1'b0, 64'd0);
    setv(14, 1'b0, 1'b1, 64'h0000_0000_8000_4004, 1'b0, 1'b1, 64'h0000_0000_8000_2000, 1'b0, 64'd0);
    setv(15, 1'b0, 1'b0, 64'd0,                  1'b0, 1'b1, 64'h0000_0000_8000_2000, 1'b0, 64'd0);
    setv(16, 1'b0, 1'b0, 64'd0,                  1'b1, 1'b1, 64'h0000_0000_8000_2000, 1'b0, 64'd0);
    setv(17, 1'b0, 1'b0, 64'd0,                  1'b1, 1'b1, 64'h0000_0000_8000_4004, 1'b0, 64'd0);
    setv(18, 1'b0, 1'b0, 64'd0,                  1'b0, 1'b1, 64'h0000_0000_8000_4008, 1'b1, 64'h0000_0000_8000_4004);
    setv(19, 1'b0, 1'b0, 64'd0,                  1'b1, 1'b1, 64'h0000_0000_8000_4008, 1'b0, 64'd0);
    setv(20, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 1'b1, 64'h0000_0000_8000_400C, 1'b1, 64'h0000_0000_8000_4008);
    setv(21, 1'b0, 1'b0, 64'd0,                  1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'd0);
    setv(22, 1'b0, 1'b0, 64'd0,                  1'b0, 1'b1, 64'd0,                  1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    setv(23, 1'b0, 1'b0, 64'd0,                  1'b0, 1'b1, 64'd0,                  1'b0, 64'd0);

    // Reset state while rst is held.
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs("rst");
    @(negedge clk);
    rst = 1'b0;

    // Table-driven cycles; outputs are register-decoded so they are
    // compared after driving this cycle's inputs, before the rising edge.
    for (int i = 0; i < NV; i++) begin
      stall          = vecs[i].stall;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      ack_en         = vecs[i].ack;
      #1;
      chk($sformatf("v%0d req", i), {63'd0, imem_req}, {63'd0, vecs[i].exp_req});
      if (vecs[i].exp_req)
        chk($sformatf("v%0d addr", i), imem_addr, vecs[i].exp_addr);
      chk($sformatf("v%0d valid", i), {63'd0, inst_valid}, {63'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) begin
        chk($sformatf("v%0d inst_addr", i), inst_addr, vecs[i].exp_iaddr);
        chk($sformatf("v%0d inst", i), {32'd0, inst}, {32'd0, vecs[i].exp_iaddr[31:0]});
      end
      @(negedge clk);
    end

    // Enter S_DROP: redirect while a request is pending without ack.
    stall          = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0000_0000_0000_0100;
    ack_en         = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    #1;
    chk("drop req", {63'd0, imem_req}, 64'd1);
    chk("drop addr", imem_addr, 64'd0);

    // Asynchronous reset between edges while in S_DROP.
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async rst");

    // Fetch restarts at RESET_PC.
    @(negedge clk);
    rst    = 1'b0;
    ack_en = 1'b1;
    #1;
    chk("restart idle req", {63'd0, imem_req}, 64'd0);
    @(negedge clk);
    #1;
    chk("restart req", {63'd0, imem_req}, 64'd1);
    chk("restart addr", imem_addr, 64'h0000_0000_8000_0000);
    @(negedge clk);
    #1;
    chk("restart valid", {63'd0, inst_valid}, 64'd1);
    chk("restart inst_addr", inst_addr, 64'h0000_0000_8000_0000);
    chk("restart inst", {32'd0, inst}, 64'h0000_0000_8000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
